// File: rtl/intc_dispatch.sv
// intc_dispatch: CPU-side interrupt dispatcher sitting after intc_top.
// Takes the level IRQ at an instruction boundary and redirects the PC to the ISR
// vector. The interrupted PC goes onto a LIFO return stack. IACK is pulsed to
// intc_top, and the saved PC is restored when the CPU executes an interrupt return.
//
// Build option: define INTC_NEST_EN to allow ISRs to be interrupted, up to
// STACK_DEPTH levels. Without it the stack has one entry and only depth 0 may take.
//
// state     | meaning
// IDLE      | waiting for iret (pop) or a takeable irq (push)
// VECTOR    | pc_load strobe to the latched ISR vector
// ACK       | iack held high for ACK_HOLD cycles
// WAIT_DROP | waiting for intc_top to release irq; iret is held pending

module intc_dispatch #(
  parameter int ADDR_W      = 32,
  parameter int STACK_DEPTH = 4,
  parameter int ACK_HOLD    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               irq,
  input  logic [ADDR_W-1:0]                  isr_addr,
  input  logic [ADDR_W-1:0]                  pc_cur,
  input  logic                               int_en,
  input  logic                               instr_boundary,
  input  logic                               iret,
  output logic                               iack,
  output logic                               pc_load,
  output logic [ADDR_W-1:0]                  pc_load_addr,
  output logic                               in_isr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   nest_depth,
  output logic                               ret_err
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
`ifdef INTC_NEST_EN
  localparam int SD = STACK_DEPTH;
`else
  localparam int SD = 1;
`endif
  localparam int CNT_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VECTOR    = 2'd1,
    ACK       = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t              state_q;
  logic [DEPTH_W-1:0]  depth_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                iack_q;
  logic                pc_load_q;
  logic [ADDR_W-1:0]   pc_load_addr_q;
  logic                ret_err_q;
  logic                iret_pend_q;
  logic [ADDR_W-1:0]   stack_q [SD];

  logic                full_d;
  logic                take_d;
  logic                ret_now_d;
  logic                push_d;
  logic [ADDR_W-1:0]   pop_pc_d;

  // Take qualification and the stack top selected by the current depth.
  always_comb begin
    full_d    = (depth_q == DEPTH_W'(SD));
    take_d    = irq & int_en & instr_boundary & ~full_d;
    ret_now_d = iret | iret_pend_q;
    push_d    = (state_q == IDLE) & ~ret_now_d & take_d;
    pop_pc_d  = '0;
    for (int i = 0; i < SD; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) pop_pc_d = stack_q[i];
    end
  end

  // Return stack storage: write pc_cur at the current depth slot on a take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SD; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < SD; i++) begin
        if (push_d && (depth_q == DEPTH_W'(i))) stack_q[i] <= pc_cur;
      end
    end
  end

  // Dispatch FSM with registered outputs and stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      depth_q        <= '0;
      cnt_q          <= '0;
      iack_q         <= 1'b0;
      pc_load_q      <= 1'b0;
      pc_load_addr_q <= '0;
      ret_err_q      <= 1'b0;
      iret_pend_q    <= 1'b0;
    end else begin
      pc_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ret_now_d) begin
            // Return has priority; a pending irq is looked at again next boundary.
            iret_pend_q <= 1'b0;
            if (depth_q != '0) begin
              pc_load_q      <= 1'b1;
              pc_load_addr_q <= pop_pc_d;
              depth_q        <= depth_q - DEPTH_W'(1);
            end else begin
              ret_err_q <= 1'b1;
            end
          end else if (take_d) begin
            // The vector is captured straight into the redirect register, so
            // isr_addr changes after this cycle have no effect.
            pc_load_q      <= 1'b1;
            pc_load_addr_q <= isr_addr;
            depth_q        <= depth_q + DEPTH_W'(1);
            state_q        <= VECTOR;
          end
        end
        VECTOR: begin
          if (iret) iret_pend_q <= 1'b1;
          iack_q  <= 1'b1;
          cnt_q   <= CNT_W'(ACK_HOLD - 1);
          state_q <= ACK;
        end
        ACK: begin
          if (iret) iret_pend_q <= 1'b1;
          if (cnt_q == '0) begin
            iack_q  <= 1'b0;
            state_q <= WAIT_DROP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WAIT_DROP: begin
          if (iret) iret_pend_q <= 1'b1;
          if (!irq) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign iack         = iack_q;
  assign pc_load      = pc_load_q;
  assign pc_load_addr = pc_load_addr_q;
  assign nest_depth   = depth_q;
  assign in_isr       = (depth_q != '0);
  assign ret_err      = ret_err_q;

endmodule

// File: tb/tb_intc_dispatch.sv
// Bench for intc_dispatch. Expected redirect targets are queued when stimulus is
// driven and popped by a monitor whenever pc_load fires.

module tb_intc_dispatch;

  localparam int ADDR_W   = 32;
  localparam int ACK_HOLD = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              irq;
  logic [ADDR_W-1:0] isr_addr;
  logic [ADDR_W-1:0] pc_cur;
  logic              int_en;
  logic              instr_boundary;
  logic              iret;
  logic              iack;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              in_isr;
  logic [2:0]        nest_depth;
  logic              ret_err;

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  int exp_acks = 0;
  int run   = 0;
  logic [ADDR_W-1:0] sb [$];

  intc_dispatch dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .isr_addr(isr_addr), .pc_cur(pc_cur),
    .int_en(int_en), .instr_boundary(instr_boundary), .iret(iret),
    .iack(iack), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .in_isr(in_isr), .nest_depth(nest_depth), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every pc_load must match the oldest queued target.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (pc_load) begin
        if (sb.size() == 0) chk("pc_load_unexpected", 64'(pc_load_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("pc_load_addr", 64'(pc_load_addr), 64'(sb.pop_front()));
      end
      if (iack) run++;
      else if (run != 0) begin
        chk("iack_len", 64'(run), 64'(ACK_HOLD));
        acks++;
        run = 0;
      end
    end
  end

  // Full take: redirect, ack pulse, irq held for a while, then dropped.
  task automatic take_seq(input logic [ADDR_W-1:0] isr, input logic [ADDR_W-1:0] pc,
                          input int exp_depth);
    irq = 1'b1; isr_addr = isr; pc_cur = pc; int_en = 1'b1; instr_boundary = 1'b1;
    sb.push_back(isr);
    exp_acks++;
    tick;
    chk("vec_pc_load", 64'(pc_load), 64'd1);
    chk("vec_iack", 64'(iack), 64'd0);
    chk("vec_depth", 64'(nest_depth), 64'(exp_depth));
    isr_addr = isr ^ 32'h0000_FFF0;
    for (int i = 0; i < ACK_HOLD; i++) begin
      tick;
      chk("ack_iack", 64'(iack), 64'd1);
      chk("ack_pc_load", 64'(pc_load), 64'd0);
    end
    tick;
    chk("drop_iack", 64'(iack), 64'd0);
    tick;
    tick;
    chk("held_irq_iack", 64'(iack), 64'd0);
    chk("in_isr", 64'(in_isr), 64'd1);
    irq = 1'b0;
    tick;
  endtask

  task automatic do_iret(input logic [ADDR_W-1:0] exp_pc, input int exp_depth);
    sb.push_back(exp_pc);
    iret = 1'b1;
    tick;
    iret = 1'b0;
    chk("ret_pc_load", 64'(pc_load), 64'd1);
    chk("ret_depth", 64'(nest_depth), 64'(exp_depth));
    chk("ret_in_isr", 64'(in_isr), 64'(exp_depth != 0));
    tick;
    chk("addr_hold", 64'(pc_load_addr), 64'(exp_pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; irq = 1'b0; isr_addr = '0; pc_cur = '0;
    int_en = 1'b0; instr_boundary = 1'b0; iret = 1'b0;
    #1;
    chk("rst_iack", 64'(iack), 64'd0);
    chk("rst_pc_load", 64'(pc_load), 64'd0);
    chk("rst_addr", 64'(pc_load_addr), 64'd0);
    chk("rst_depth", 64'(nest_depth), 64'd0);
    chk("rst_in_isr", 64'(in_isr), 64'd0);
    chk("rst_ret_err", 64'(ret_err), 64'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Basic take and return.
    take_seq(32'h100, 32'h40, 1);
    chk("t1_depth", 64'(nest_depth), 64'd1);
    do_iret(32'h40, 0);

    // Return with empty stack: sticky error, no redirect.
    iret = 1'b1;
    tick;
    iret = 1'b0;
    chk("t3_ret_err", 64'(ret_err), 64'd1);
    chk("t3_pc_load", 64'(pc_load), 64'd0);
    chk("t3_depth", 64'(nest_depth), 64'd0);
    repeat (3) tick;
    chk("t3_ret_err_sticky", 64'(ret_err), 64'd1);

    take_seq(32'h100, 32'h40, 1);
`ifdef INTC_NEST_EN
    take_seq(32'h200, 32'h108, 2);
    do_iret(32'h108, 1);
    do_iret(32'h40, 0);
    for (int i = 0; i < 4; i++) take_seq(32'h1000 + 32'(i * 16), 32'h80 + 32'(i * 4), i + 1);
    irq = 1'b1; isr_addr = 32'h9000; int_en = 1'b1; instr_boundary = 1'b1;
    repeat (6) begin
      tick;
      chk("full_iack", 64'(iack), 64'd0);
      chk("full_depth", 64'(nest_depth), 64'd4);
    end
    irq = 1'b0;
    tick;
    for (int i = 3; i >= 0; i--) do_iret(32'h80 + 32'(i * 4), i);
    take_seq(32'h100, 32'h40, 1);
`else
    irq = 1'b1; isr_addr = 32'h200; pc_cur = 32'h108; int_en = 1'b1; instr_boundary = 1'b1;
    repeat (6) begin
      tick;
      chk("nonest_iack", 64'(iack), 64'd0);
      chk("nonest_depth", 64'(nest_depth), 64'd1);
    end
    irq = 1'b0;
    tick;
`endif

    // iret and take in the same IDLE cycle: return first, then take.
    irq = 1'b1; isr_addr = 32'h300; pc_cur = 32'h50; int_en = 1'b1; instr_boundary = 1'b1;
    iret = 1'b1;
    sb.push_back(32'h40);
    sb.push_back(32'h300);
    exp_acks++;
    tick;
    iret = 1'b0;
    chk("t5_ret_load", 64'(pc_load), 64'd1);
    chk("t5_ret_depth", 64'(nest_depth), 64'd0);
    chk("t5_ret_iack", 64'(iack), 64'd0);
    tick;
    chk("t5_take_load", 64'(pc_load), 64'd1);
    chk("t5_take_depth", 64'(nest_depth), 64'd1);
    for (int i = 0; i < ACK_HOLD; i++) begin
      tick;
      chk("t5_iack", 64'(iack), 64'd1);
    end
    tick;
    chk("t5_iack_off", 64'(iack), 64'd0);
    irq = 1'b0;
    tick;
    do_iret(32'h50, 0);

    // Gating: int_en low, then boundary low.
    irq = 1'b1; isr_addr = 32'h400; int_en = 1'b0; instr_boundary = 1'b1;
    repeat (4) begin
      tick;
      chk("int_en_gate", 64'(nest_depth), 64'd0);
    end
    int_en = 1'b1; instr_boundary = 1'b0;
    repeat (4) begin
      tick;
      chk("boundary_gate", 64'(nest_depth), 64'd0);
      chk("boundary_iack", 64'(iack), 64'd0);
    end
    irq = 1'b0; instr_boundary = 1'b1;
    tick;

    // iret during WAIT_DROP is serviced on the first IDLE cycle.
    irq = 1'b1; isr_addr = 32'h500; pc_cur = 32'h60;
    sb.push_back(32'h500);
    exp_acks++;
    tick;
    repeat (ACK_HOLD) tick;
    tick;
    iret = 1'b1;
    tick;
    iret = 1'b0;
    chk("pend_no_load", 64'(pc_load), 64'd0);
    irq = 1'b0;
    sb.push_back(32'h60);
    tick;
    chk("pend_idle_load", 64'(pc_load), 64'd0);
    tick;
    chk("pend_load", 64'(pc_load), 64'd1);
    chk("pend_depth", 64'(nest_depth), 64'd0);
    chk("ret_err_kept", 64'(ret_err), 64'd1);

    // Reset during ACK: iack drops at once, stack discarded, irq re-taken.
    irq = 1'b1; isr_addr = 32'h700; pc_cur = 32'h70;
    sb.push_back(32'h700);
    tick;
    tick;
    chk("t6_iack_pre", 64'(iack), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_iack_async", 64'(iack), 64'd0);
    chk("t6_depth", 64'(nest_depth), 64'd0);
    chk("t6_ret_err", 64'(ret_err), 64'd0);
    tick;
    rst_n = 1'b1;
    pc_cur = 32'h74;
    sb.push_back(32'h700);
    exp_acks++;
    tick;
    chk("t6_retake_load", 64'(pc_load), 64'd1);
    chk("t6_retake_depth", 64'(nest_depth), 64'd1);
    repeat (ACK_HOLD) tick;
    tick;
    irq = 1'b0;
    tick;
    do_iret(32'h74, 0);

    repeat (3) tick;
    chk("sb_left", 64'(sb.size()), 64'd0);
    chk("ack_count", 64'(acks), 64'(exp_acks));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
